// File: rtl/qdiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// qdiv_ctrl_if
// Bundles the three handshakes of qdiv_ctrl: the request stream (s_*), the
// result stream (m_*) and the start/complete link to the iterative divider
// (div_*), plus the busy status flag.
//   slave  : view used by qdiv_ctrl (consumes requests, produces results,
//            drives the divider).
//   master : view used by the environment (request source, result sink and
//            divider).
// Parameters: N (word width incl. sign), TAG_W (request tag width).
// -----------------------------------------------------------------------------
interface qdiv_ctrl_if #(
  parameter int N     = 32,
  parameter int TAG_W = 4
);
  // request stream
  logic             s_valid;
  logic             s_ready;
  logic [N-1:0]     s_dividend;
  logic [N-1:0]     s_divisor;
  logic [TAG_W-1:0] s_tag;
  // result stream
  logic             m_valid;
  logic             m_ready;
  logic [N-1:0]     m_quotient;
  logic [TAG_W-1:0] m_tag;
  logic             m_ovf;
  logic             m_dz;
  // divider link
  logic             div_start;
  logic [N-1:0]     div_dividend;
  logic [N-1:0]     div_divisor;
  logic             div_complete;
  logic [N-1:0]     div_quotient;
  logic             div_overflow;
  // status
  logic             busy;

  modport slave (
    input  s_valid, s_dividend, s_divisor, s_tag,
    output s_ready,
    input  m_ready,
    output m_valid, m_quotient, m_tag, m_ovf, m_dz,
    output div_start, div_dividend, div_divisor,
    input  div_complete, div_quotient, div_overflow,
    output busy
  );

  modport master (
    output s_valid, s_dividend, s_divisor, s_tag,
    input  s_ready,
    output m_ready,
    input  m_valid, m_quotient, m_tag, m_ovf, m_dz,
    input  div_start, div_dividend, div_divisor,
    output div_complete, div_quotient, div_overflow,
    input  busy
  );
endinterface

// File: rtl/qdiv_ctrl.sv
// -----------------------------------------------------------------------------
// qdiv_ctrl
// Request sequencer and result buffer around the iterative sign-magnitude
// Q-format divider. Requests are accepted one at a time; divide-by-zero is
// resolved locally without starting the divider, overflowed quotients are
// saturated, and tagged results are returned through a 2-entry
// first-word-fall-through FIFO so the divider can finish while the result
// consumer stalls.
//
// Ports:
//   i_clk   : clock
//   i_rstn  : synchronous active-low reset (the divider must share it)
//   bus     : qdiv_ctrl_if.slave
//             s_valid/s_ready/s_dividend/s_divisor/s_tag   request stream
//             m_valid/m_ready/m_quotient/m_tag/m_ovf/m_dz  result stream
//             div_start/div_dividend/div_divisor           divider command
//             div_complete/div_quotient/div_overflow       divider response
//             busy                                         high in ISSUE/BUSY
//
// Build option:
//   QDIV_CTRL_TWOS_COMP_OUT_EN - when defined, m_quotient is delivered in
//   N-bit two's complement (after saturation) and one register stage is
//   inserted ahead of the FIFO write, adding one cycle to every result.
// -----------------------------------------------------------------------------
module qdiv_ctrl #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int TAG_W = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  qdiv_ctrl_if.slave bus
);

  // FIFO entry layout: {quotient, tag, ovf, dz}
  localparam int E_W = N + TAG_W + 2;

  // The magnitude must hold at least one integer and one fraction bit.
  if ((Q < 1) || (Q > (N - 2))) begin : g_bad_q
    $error("qdiv_ctrl: Q out of range for N");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Sign-magnitude word with negative zero folded onto +0.
  function automatic logic [N-1:0] sm_word(input logic sign, input logic [N-2:0] mag);
    logic [N-1:0] w;
    if (mag == {(N-1){1'b0}}) begin
      w = {N{1'b0}};
    end else begin
      w = {sign, mag};
    end
    return w;
  endfunction

  function automatic logic [E_W-1:0] pack_entry(input logic [N-1:0] q,
                                                input logic [TAG_W-1:0] t,
                                                input logic ovf,
                                                input logic dz);
    return {q, t, ovf, dz};
  endfunction

`ifdef QDIV_CTRL_TWOS_COMP_OUT_EN
  // Sign-magnitude to two's complement; the all-ones negative magnitude maps
  // to -(2^(N-1)-1), so saturation never produces the most negative code.
  function automatic logic [N-1:0] to_twos(input logic [N-1:0] sm);
    logic [N-1:0] r;
    if (sm[N-1]) begin
      r = {N{1'b0}} - {1'b0, sm[N-2:0]};
    end else begin
      r = sm;
    end
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             busy_first_q, busy_first_d;
  logic [N-1:0]     dividend_q, dividend_d;
  logic [N-1:0]     divisor_q, divisor_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [E_W-1:0]   mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q, count_d;

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  logic             ready_s;
  logic             accept_s;
  logic             dz_s;
  logic             done_s;
  logic             pop_s;
  logic             push_s;
  logic [E_W-1:0]   push_entry_s;
  logic [1:0]       occ_s;
  logic [E_W-1:0]   head_s;

  logic             res_push_s;
  logic             res_sign_s;
  logic [N-2:0]     res_mag_s;
  logic             res_ovf_s;
  logic             res_dz_s;
  logic [TAG_W-1:0] res_tag_s;
  logic [N-1:0]     res_word_s;
  logic [N-1:0]     out_word_s;
  logic [E_W-1:0]   res_entry_s;

  // A request is only taken when the divider is idle and a FIFO slot (counting
  // any result still in the output register) is free, so the single in-flight
  // op always has somewhere to land.
  assign ready_s  = i_rstn & (state_q == ST_IDLE) & bus.div_complete & (occ_s < 2'd2);
  assign accept_s = bus.s_valid & ready_s;
  assign dz_s     = (bus.s_divisor[N-2:0] == {(N-1){1'b0}});
  // The first BUSY cycle may still see the divider's pre-start complete flag.
  assign done_s   = (state_q == ST_BUSY) & ~busy_first_q & bus.div_complete;
  assign pop_s    = bus.m_valid & bus.m_ready;

  // Next-state and divider command decode for the issue sequencer.
  always_comb begin
    state_d      = state_q;
    busy_first_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !dz_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d      = ST_BUSY;
        busy_first_d = 1'b1;
      end
      ST_BUSY: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand/tag capture on every accepted request (DZ included).
  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    tag_d      = tag_q;
    if (accept_s) begin
      dividend_d = bus.s_dividend;
      divisor_d  = bus.s_divisor;
      tag_d      = bus.s_tag;
    end else begin
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      tag_d      = tag_q;
    end
  end

  // Result formation: local DZ result at accept, or divider result at done.
  always_comb begin
    res_push_s = 1'b0;
    res_sign_s = 1'b0;
    res_mag_s  = {(N-1){1'b0}};
    res_ovf_s  = 1'b0;
    res_dz_s   = 1'b0;
    res_tag_s  = {TAG_W{1'b0}};
    if (accept_s && dz_s) begin
      res_push_s = 1'b1;
      res_sign_s = bus.s_dividend[N-1] ^ bus.s_divisor[N-1];
      res_mag_s  = {(N-1){1'b1}};
      res_dz_s   = 1'b1;
      res_tag_s  = bus.s_tag;
    end else if (done_s) begin
      res_push_s = 1'b1;
      res_sign_s = bus.div_quotient[N-1];
      if (bus.div_overflow) begin
        res_mag_s = {(N-1){1'b1}};
      end else begin
        res_mag_s = bus.div_quotient[N-2:0];
      end
      res_ovf_s  = bus.div_overflow;
      res_tag_s  = tag_q;
    end else begin
      res_push_s = 1'b0;
    end
  end

  assign res_word_s = sm_word(res_sign_s, res_mag_s);

`ifdef QDIV_CTRL_TWOS_COMP_OUT_EN
  logic           pipe_vld_q;
  logic [E_W-1:0] pipe_q;

  assign out_word_s  = to_twos(res_word_s);
  assign res_entry_s = pack_entry(out_word_s, res_tag_s, res_ovf_s, res_dz_s);

  // Output-format register between result formation and the FIFO write.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pipe_vld_q <= 1'b0;
      pipe_q     <= {E_W{1'b0}};
    end else begin
      pipe_vld_q <= res_push_s;
      if (res_push_s) begin
        pipe_q <= res_entry_s;
      end
    end
  end

  assign push_s       = pipe_vld_q;
  assign push_entry_s = pipe_q;
  assign occ_s        = count_q + {1'b0, pipe_vld_q};
`else
  assign out_word_s   = res_word_s;
  assign res_entry_s  = pack_entry(out_word_s, res_tag_s, res_ovf_s, res_dz_s);
  assign push_s       = res_push_s;
  assign push_entry_s = res_entry_s;
  assign occ_s        = count_q;
`endif

  // FIFO occupancy; simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Sequencer, operand and tag registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      busy_first_q <= 1'b0;
      dividend_q   <= {N{1'b0}};
      divisor_q    <= {N{1'b0}};
      tag_q        <= {TAG_W{1'b0}};
    end else begin
      state_q      <= state_d;
      busy_first_q <= busy_first_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      tag_q        <= tag_d;
    end
  end

  // Two-entry result FIFO storage and pointers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      mem_q[0] <= {E_W{1'b0}};
      mem_q[1] <= {E_W{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_entry_s;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head of FIFO falls through; storage only changes on a write to
  // the other slot or on reset, so the head is stable while stalled.
  // ---------------------------------------------------------------------------
  assign head_s           = mem_q[rd_ptr_q];
  assign bus.m_valid      = (count_q != 2'd0);
  assign bus.m_quotient   = head_s[E_W-1 -: N];
  assign bus.m_tag        = head_s[TAG_W+1:2];
  assign bus.m_ovf        = head_s[1];
  assign bus.m_dz         = head_s[0];

  assign bus.s_ready      = ready_s;
  assign bus.div_start    = (state_q == ST_ISSUE);
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qdiv_ctrl
// Directed bench for qdiv_ctrl. A behavioural divider taking N+Q cycles from
// start to complete sits on the div_* link. Results are collected at the
// falling edge whenever m_valid&m_ready and compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_qdiv_ctrl;
  localparam int Q     = 15;
  localparam int N     = 32;
  localparam int TAG_W = 4;
`ifdef QDIV_CTRL_TWOS_COMP_OUT_EN
  localparam int LAT_NORM = 51;
  localparam int LAT_DZ   = 2;
`else
  localparam int LAT_NORM = 50;
  localparam int LAT_DZ   = 1;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  qdiv_ctrl_if #(.N(N), .TAG_W(TAG_W)) bus ();

  qdiv_ctrl #(.Q(Q), .N(N), .TAG_W(TAG_W)) u_dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int start_cnt = 0;
  logic [37:0] got_q [$];

  // ---------------- behavioural divider ----------------
  logic [7:0]  dcnt;
  logic [31:0] dq;
  logic        dovf;

  function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] qq;
    logic [32:0] r;
    if (b[30:0] == 31'd0) begin
      r = 33'd0;
    end else begin
      qq = ({33'd0, a[30:0]} << Q) / {33'd0, b[30:0]};
      r  = {(qq[63:31] != 33'd0), a[31] ^ b[31], qq[30:0]};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      dcnt <= 8'd0;
      dq   <= 32'd0;
      dovf <= 1'b0;
    end else if (bus.div_start) begin
      dcnt <= 8'(N + Q);
      {dovf, dq} <= div_model(bus.div_dividend, bus.div_divisor);
    end else if (dcnt != 8'd0) begin
      dcnt <= dcnt - 8'd1;
    end
  end

  assign bus.div_complete = (dcnt == 8'd0);
  assign bus.div_quotient = dq;
  assign bus.div_overflow = dovf;

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (bus.div_start) start_cnt++;
    if (bus.m_valid && bus.m_ready)
      got_q.push_back({bus.m_quotient, bus.m_tag, bus.m_ovf, bus.m_dz});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] exp_out(input logic [31:0] sm);
`ifdef QDIV_CTRL_TWOS_COMP_OUT_EN
    if (sm[31]) return 32'd0 - {1'b0, sm[30:0]};
    return sm;
`else
    return sm;
`endif
  endfunction

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int w;
    @(negedge clk);
    bus.s_valid    = 1'b1;
    bus.s_dividend = a;
    bus.s_divisor  = b;
    bus.s_tag      = tag;
    w = 0;
    while (!bus.s_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk_val("accept", bus.s_ready, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 400 && got_q.size() < n; i++) @(negedge clk);
    @(negedge clk);
    chk_val("result_count", got_q.size(), n);
  endtask

  task automatic chk_entry(input string nm, input int idx, input logic [31:0] q,
                           input logic [3:0] tag, input logic ovf, input logic dz);
    logic [37:0] e;
    if (got_q.size() > idx) begin
      e = got_q[idx];
      chk_val({nm, "_quot"}, e[37:6], exp_out(q));
      chk_val({nm, "_tag"},  e[5:2],  tag);
      chk_val({nm, "_ovf"},  e[1],    ovf);
      chk_val({nm, "_dz"},   e[0],    dz);
    end
  endtask

  // Accept-to-m_valid latency: 1 means m_valid is high in the cycle right
  // after the accepting edge.
  task automatic measure_lat(input string nm, input int exp_lat);
    int lat;
    lat = 1;
    while (!bus.m_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk_val({nm, "_lat"}, lat, exp_lat);
  endtask

  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] q,
                         input logic ovf, input logic dz, input int exp_lat);
    got_q.delete();
    send(a, b, tag);
    measure_lat(nm, exp_lat);
    wait_results(1);
    chk_entry(nm, 0, q, tag, ovf, dz);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sc0;
    int w;
    logic sr_seen;
    logic [31:0] bp_q [3];
    bus.s_valid = 1'b0;
    bus.s_dividend = 32'd0;
    bus.s_divisor  = 32'd0;
    bus.s_tag      = 4'd0;
    bus.m_ready    = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk_val("rst_s_ready",  bus.s_ready, 0);
    chk_val("rst_m_valid",  bus.m_valid, 0);
    chk_val("rst_div_start", bus.div_start, 0);
    chk_val("rst_busy",     bus.busy, 0);
    chk_val("rst_div_operands", {bus.div_dividend, bus.div_divisor}, 64'd0);
    chk_val("rst_head", {bus.m_quotient, bus.m_tag, bus.m_ovf, bus.m_dz}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk_val("idle_s_ready", bus.s_ready, 1);

    // 3.0 / 2.0 and single start pulse
    sc0 = start_cnt;
    run_one("pos_div", 32'h00018000, 32'h00010000, 4'd3, 32'h0000C000, 1'b0, 1'b0, LAT_NORM);
    chk_val("one_start_pulse", start_cnt - sc0, 1);

    // -3.0 / 2.0
    run_one("neg_div", 32'h80018000, 32'h00010000, 4'd4, 32'h8000C000, 1'b0, 1'b0, LAT_NORM);

    // divide by zero, back to back: second accept overlaps the first pop
    sc0 = start_cnt;
    got_q.delete();
    send(32'h00028000, 32'h00000000, 4'd1);
    measure_lat("dz_pos", LAT_DZ);
    send(32'h00028000, 32'h80000000, 4'd2);
    wait_results(2);
    chk_entry("dz_pos", 0, 32'h7FFFFFFF, 4'd1, 1'b0, 1'b1);
    chk_entry("dz_neg", 1, 32'hFFFFFFFF, 4'd2, 1'b0, 1'b1);
    run_one("dz_zero", 32'h00000000, 32'h00000000, 4'd6, 32'h7FFFFFFF, 1'b0, 1'b1, LAT_DZ);
    chk_val("dz_no_start", start_cnt - sc0, 0);

    // overflow saturation
    run_one("ovf", 32'h7FFF0000, 32'h00000001, 4'd8, 32'h7FFFFFFF, 1'b1, 1'b0, LAT_NORM);

    // negative zero folds to +0
    run_one("neg_zero", 32'h80000000, 32'h00008000, 4'd11, 32'h00000000, 1'b0, 1'b0, LAT_NORM);

    // backpressure
    got_q.delete();
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    send(32'h00008000, 32'h00008000, 4'd5);
    send(32'h00010000, 32'h00008000, 4'd6);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_dividend = 32'h00008000;
    bus.s_divisor  = 32'h00010000;
    bus.s_tag      = 4'd7;
    w = 0;
    while (bus.busy && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk_val("bp_idle", bus.busy, 0);
    sr_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      sr_seen = sr_seen | bus.s_ready;
    end
    chk_val("bp_s_ready_full", sr_seen, 0);
    chk_val("bp_m_valid", bus.m_valid, 1);
    chk_val("bp_head_hold", {bus.m_quotient, bus.m_tag}, {exp_out(32'h00008000), 4'd5});
    chk_val("bp_no_pop", got_q.size(), 0);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    w = 0;
    while (!bus.s_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk_val("bp_accept3", bus.s_ready, 1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    wait_results(3);
    bp_q[0] = 32'h00008000;
    bp_q[1] = 32'h00010000;
    bp_q[2] = 32'h00004000;
    for (int i = 0; i < 3; i++) chk_entry("bp", i, bp_q[i], 4'(5 + i), 1'b0, 1'b0);

    // reset mid-operation
    got_q.delete();
    send(32'h00018000, 32'h00010000, 4'd9);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_val("mid_rst_busy",    bus.busy, 0);
    chk_val("mid_rst_m_valid", bus.m_valid, 0);
    chk_val("mid_rst_start",   bus.div_start, 0);
    chk_val("mid_rst_s_ready", bus.s_ready, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    chk_val("mid_rst_abandoned", got_q.size(), 0);
    run_one("after_rst", 32'h00008000, 32'h00008000, 4'd10, 32'h00008000, 1'b0, 1'b0, LAT_NORM);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
